// File: rtl/ibex_multdiv_iter.sv
// Iterative radix-2^BITS_PER_CYCLE multiplier/divider with its own adder and valid/ready handshakes.
// Optional busy-cycle counter enabled by defining IBEX_MULTDIV_ITER_PERF_EN.
module ibex_multdiv_iter #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] result_o
`ifdef IBEX_MULTDIV_ITER_PERF_EN
    ,
    output logic [31:0]      perf_busy_cycles_o,
    input  logic [0:0]       perf_clr_i
`endif
);

    localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (!((WIDTH == 32) || (WIDTH == 64)) ||
        !((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)) ||
        ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_param
        $error("ibex_multdiv_iter: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        COMP  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    md_op_e               op_q;
    logic                 sign_a_q, sign_b_q, dit_q, neg_q;
    logic [WIDTH-1:0]     op_a_q, op_b_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     result_q;

    logic                 accept, is_div, b_zero, early_dz;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   mul_acc, comp_acc, comp_mcand, prod_fix;
    logic [WIDTH-1:0]     comp_mplier, div_rem, div_quo, div_dvd, quo_fix, rem_fix, fix_result;
    logic [WIDTH:0]       trial;
    logic                 div_ge;

    assign accept       = req_valid_i && (state_q == IDLE) && !kill_i;
    assign is_div       = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
    assign b_zero       = (op_b_q == '0);
    assign early_dz     = is_div && b_zero && !dit_q;
    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign result_o     = result_q;

    always_comb begin
        mag_a = sign_a_q ? -op_a_q : op_a_q;
        mag_b = sign_b_q ? -op_b_q : op_b_q;

        // Shift-add: mcand_q already carries the weight of the current digit.
        mul_acc = acc_q;
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) mul_acc = mul_acc + (mcand_q << j);
        end

        // Restoring division: remainder in acc high half, quotient shifts into the low half,
        // dividend bits are pulled from the MSB of mplier_q.
        div_rem = acc_q[2*WIDTH-1:WIDTH];
        div_quo = acc_q[WIDTH-1:0];
        div_dvd = mplier_q;
        trial   = '0;
        div_ge  = 1'b0;
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            trial   = {div_rem, div_dvd[WIDTH-1]};
            div_dvd = div_dvd << 1;
            div_ge  = (trial >= {1'b0, mcand_q[WIDTH-1:0]});
            div_rem = div_ge ? (trial[WIDTH-1:0] - mcand_q[WIDTH-1:0]) : trial[WIDTH-1:0];
            div_quo = {div_quo[WIDTH-2:0], div_ge};
        end

        comp_acc    = is_div ? {div_rem, div_quo} : mul_acc;
        comp_mcand  = is_div ? mcand_q : (mcand_q << BITS_PER_CYCLE);
        comp_mplier = is_div ? div_dvd : (mplier_q >> BITS_PER_CYCLE);

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = (neg_q && !b_zero) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            MD_OP_MULL: fix_result = prod_fix[WIDTH-1:0];
            MD_OP_MULH: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            MD_OP_DIV:  fix_result = quo_fix;
            default:    fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = PREP;
            PREP:  state_d = early_dz ? DONE : COMP;
            COMP: begin
                if ((cnt_q == '0) || (!is_div && !dit_q && (comp_mplier == '0))) state_d = FIXUP;
            end
            FIXUP: state_d = DONE;
            DONE:  if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= MD_OP_MULL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dit_q    <= 1'b0;
            neg_q    <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= md_op_e'(operator_i);
                sign_a_q <= op_a_i[WIDTH-1] & signed_mode_i[0];
                sign_b_q <= op_b_i[WIDTH-1] & signed_mode_i[1];
                op_a_q   <= op_a_i;
                op_b_q   <= op_b_i;
                dit_q    <= data_ind_timing_i;
            end
            case (state_q)
                PREP: begin
                    neg_q <= (op_q == MD_OP_REM) ? sign_a_q : (sign_a_q ^ sign_b_q);
                    cnt_q <= CW'(N - 1);
                    acc_q <= '0;
                    if (is_div) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag_b};
                        mplier_q <= mag_a;
                    end else begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                    end
                    if (early_dz) result_q <= (op_q == MD_OP_DIV) ? '1 : op_a_q;
                end
                COMP: begin
                    acc_q    <= comp_acc;
                    mcand_q  <= comp_mcand;
                    mplier_q <= comp_mplier;
                    cnt_q    <= cnt_q - CW'(1);
                end
                FIXUP:   result_q <= fix_result;
                default: ;
            endcase
        end
    end

`ifdef IBEX_MULTDIV_ITER_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                               perf_q <= '0;
        else if (perf_clr_i[0])                                    perf_q <= '0;
        else if ((state_q != IDLE) && (state_q != DONE) && (perf_q != '1)) perf_q <= perf_q + 32'd1;
    end
    assign perf_busy_cycles_o = perf_q;
`endif

    a_state_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q inside {IDLE, PREP, COMP, FIXUP, DONE});

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Scoreboard bench: three WIDTH=32 instances (1, 2 and 4 bits per cycle) checked against an arithmetic model.
module tb_ibex_multdiv_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  req_valid, req_ready, resp_valid, resp_ready, kill, dit;
    logic [1:0]  opr [3];
    logic [1:0]  sm  [3];
    logic [31:0] a   [3];
    logic [31:0] b   [3];
    logic [31:0] res [3];
`ifdef IBEX_MULTDIV_ITER_PERF_EN
    logic [31:0] perf [3];
    logic [2:0]  perf_clr;
`endif

    for (genvar k = 0; k < 3; k++) begin : g_dut
        ibex_multdiv_iter #(.WIDTH(32), .BITS_PER_CYCLE(1 << k)) u_dut (
            .clk_i            (clk),
            .rst_ni           (rst_n),
            .req_valid_i      (req_valid[k]),
            .req_ready_o      (req_ready[k]),
            .operator_i       (opr[k]),
            .signed_mode_i    (sm[k]),
            .op_a_i           (a[k]),
            .op_b_i           (b[k]),
            .data_ind_timing_i(dit[k]),
            .kill_i           (kill[k]),
            .resp_valid_o     (resp_valid[k]),
            .resp_ready_i     (resp_ready[k]),
            .result_o         (res[k])
`ifdef IBEX_MULTDIV_ITER_PERF_EN
            ,
            .perf_busy_cycles_o(perf[k]),
            .perf_clr_i        (perf_clr[k])
`endif
        );
    end

    typedef struct {
        int          d;
        logic [31:0] res;
        int          acc;
        int          lmin;
        int          lmax;
    } exp_t;

    exp_t        sb[$];
    string       cq_n[$];
    logic [31:0] cq_a[$];
    logic [31:0] cq_e[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model(logic [1:0] op, logic [1:0] s, logic [31:0] x, logic [31:0] y);
        logic [63:0] xe, ye, p;
        longint      sx, sy;
        xe = s[0] ? {{32{x[31]}}, x} : {32'h0, x};
        ye = s[1] ? {{32{y[31]}}, y} : {32'h0, y};
        sx = xe;
        sy = ye;
        p  = xe * ye;
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                p = sx / sy;
                return p[31:0];
            end
            default: begin
                if (y == 32'h0) return x;
                p = sx % sy;
                return p[31:0];
            end
        endcase
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        cq_n.push_back(n);
        cq_a.push_back(act);
        cq_e.push_back(exp);
    endtask

    // Monitor: drains point checks and compares every presented response against the scoreboard head.
    int  first [3];
    bit  seen  [3];
    initial forever begin
        @(negedge clk);
        while (cq_n.size() > 0) begin
            n_chk = n_chk + 1;
            if (cq_a[0] !== cq_e[0]) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %h expected %h", cq_n[0], cq_a[0], cq_e[0]);
            end
            void'(cq_n.pop_front());
            void'(cq_a.pop_front());
            void'(cq_e.pop_front());
        end
        for (int d = 0; d < 3; d++) begin
            if (rst_n && resp_valid[d]) begin
                if (sb.size() == 0 || sb[0].d != d) begin
                    n_chk  = n_chk + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_resp dut%0d: got result %h, expected no response", d, res[d]);
                end else begin
                    if (!seen[d]) begin
                        seen[d]  = 1'b1;
                        first[d] = cyc;
                    end
                    n_chk = n_chk + 1;
                    if (res[d] !== sb[0].res) begin
                        n_fail = n_fail + 1;
                        $display("FAIL result dut%0d: got %h expected %h", d, res[d], sb[0].res);
                    end
                    if (resp_ready[d]) begin
                        int lat;
                        lat   = first[d] - sb[0].acc + 1;
                        n_chk = n_chk + 1;
                        if (lat < sb[0].lmin || lat > sb[0].lmax) begin
                            n_fail = n_fail + 1;
                            $display("FAIL latency dut%0d: got %0d expected %0d..%0d", d, lat, sb[0].lmin, sb[0].lmax);
                        end
                        void'(sb.pop_front());
                        seen[d] = 1'b0;
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(int d, logic [1:0] op, logic [1:0] s, logic [31:0] x, logic [31:0] y,
                         logic di, int lmin, int lmax, bit push);
        int t = 0;
        exp_t e;
        while (!req_ready[d] && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready[d]) begin
            chk("req_ready_timeout", {31'h0, req_ready[d]}, 32'h1);
            return;
        end
        opr[d] = op; sm[d] = s; a[d] = x; b[d] = y; dit[d] = di;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        opr[d] = 2'($urandom); sm[d] = 2'($urandom); a[d] = $urandom; b[d] = $urandom; dit[d] = 1'($urandom);
        if (push) begin
            e.d = d; e.res = model(op, s, x, y); e.acc = cyc; e.lmin = lmin; e.lmax = lmax;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() > 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() > 0) begin
            chk("resp_timeout", sb.size(), 32'h0);
            sb.delete();
        end
    endtask

    task automatic run(int d, logic [1:0] op, logic [1:0] s, logic [31:0] x, logic [31:0] y, logic di);
        int n, lmin, lmax;
        n = 32 >> d;
        lmin = n + 3; lmax = n + 3;
        if (op[1] && y == 32'h0 && !di) begin
            lmin = 2; lmax = 2;
        end else if (!op[1] && !di) begin
            lmin = 4;
        end
        issue(d, op, s, x, y, di, lmin, lmax, 1'b1);
        wait_done();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        req_valid = '0; kill = '0; resp_ready = '1; dit = '0;
        for (int d = 0; d < 3; d++) begin
            opr[d] = '0; sm[d] = '0; a[d] = '0; b[d] = '0;
        end
`ifdef IBEX_MULTDIV_ITER_PERF_EN
        perf_clr = '0;
`endif
        #2;
        for (int d = 0; d < 3; d++) begin
            chk("reset_req_ready", {31'h0, req_ready[d]}, 32'h1);
            chk("reset_resp_valid", {31'h0, resp_valid[d]}, 32'h0);
            chk("reset_result", res[d], 32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 2'd0, 2'b11, 32'd7, 32'd6, 1'b1);
        run(1, 2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run(1, 2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run(0, 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(0, 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(0, 2'd2, 2'b00, 32'd5, 32'd0, 1'b0);
        run(0, 2'd3, 2'b00, 32'd5, 32'd0, 1'b1);
        run(0, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run(0, 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run(2, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd0, 1'b1);
        run(2, 2'd0, 2'b00, 32'd12345, 32'd3, 1'b0);

        // Kill mid-computation: no response, ready again on the next cycle.
        issue(0, 2'd0, 2'b00, 32'd11, 32'd13, 1'b1, 0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1 kill[0] = 1'b1;
        @(posedge clk); #1;
        kill[0] = 1'b0;
        chk("kill_ready", {31'h0, req_ready[0]}, 32'h1);
        chk("kill_valid", {31'h0, resp_valid[0]}, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        // Kill in IDLE blocks acceptance.
        kill[0] = 1'b1; req_valid[0] = 1'b1; opr[0] = 2'd0; a[0] = 32'd2; b[0] = 32'd2;
        @(posedge clk); #1;
        kill[0] = 1'b0; req_valid[0] = 1'b0;
        chk("kill_idle_block", {31'h0, req_ready[0]}, 32'h1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: result must stay stable while resp_ready is low.
        resp_ready[0] = 1'b0;
        issue(0, 2'd0, 2'b00, 32'd3, 32'd3, 1'b1, 35, 35, 1'b1);
        begin
            int t = 0;
            while (!resp_valid[0] && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
        end
        repeat (5) @(posedge clk);
        #1 resp_ready[0] = 1'b1;
        wait_done();
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            run(i % 3, 2'($urandom), 2'($urandom), pick(), pick(), 1'($urandom));
        end

`ifdef IBEX_MULTDIV_ITER_PERF_EN
        perf_clr[2] = 1'b1;
        @(posedge clk); #1;
        perf_clr[2] = 1'b0;
        run(2, 2'd2, 2'b00, 32'd1000, 32'd7, 1'b1);
        run(2, 2'd2, 2'b11, 32'hFFFF_0000, 32'd9, 1'b1);
        chk("perf_count", perf[2], 32'd20);
        perf_clr[2] = 1'b1;
        @(posedge clk); #1;
        perf_clr[2] = 1'b0;
        chk("perf_clear", perf[2], 32'd0);
`endif

        wait_done();
        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
